add_h_border: RTL and testbench
===============================

Name: add_h_border

Overview:
- Multi-flux border inserter for the 8-pixel HEVC interpolation datapath.
- For each block row it emits one left padding word, then the row's interior words, then one right padding word. Output rows are W+2*N_TAP pixels wide.
- Padding words replicate the row's first or last pixel.
- Sits upstream of the interpolation filters. It is the inverse of the horizontal border-removal stage: per-flux state is kept in registers, and one flux is served per cycle using tag-multiplexed FIFO ports.

Parameters:
- FLUX, 2, number of interleaved data fluxes (>=2); TAG_W = $clog2(FLUX).
- N_TAP, 8, pixels per word and padding width per side.
- PEL_W, 8, bits per pixel.
- SIZE_W, 7, width of the block-size token.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_pel_dout  in  TAG_W+N_TAP*PEL_W  head word of the pel FIFO. Pixel 0 is in the LSBs; tag bits are ignored.
- in_pel_empty  in  FLUX  per-flux empty flags, first-word-fall-through
- in_pel_read  out  FLUX  one-hot pop of the pel FIFO
- ext_size_dout  in  TAG_W+SIZE_W  block width W in pixels (the low SIZE_W bits)
- ext_size_empty  in  FLUX  per-flux empty flags
- ext_size_read  out  FLUX  one-hot pop of the size FIFO
- out_pel_din  out  TAG_W+N_TAP*PEL_W  {tag, word}
- out_pel_full  in  FLUX  per-flux full flags
- out_pel_write  out  1  write strobe

Behaviour:
- Reset: all flux states go to IDLE; cnt_h, cnt_v, max and last_pel go to 0.
  - Outputs are combinational from state. With no eligible flux: in_pel_read=0, ext_size_read=0, out_pel_write=0, out_pel_din don't-care.
- Per-flux registers:
  - state[2]: IDLE, LEFT, MID, RIGHT
  - max[SIZE_W]
  - cnt_h[SIZE_W], counts pixels consumed in the current row
  - cnt_v[SIZE_W], counts rows completed
  - last_pel[PEL_W]
- Eligibility conditions:
  - IDLE: ext_size not empty.
  - LEFT and MID: in_pel not empty and out_pel not full.
  - RIGHT: out_pel not full.
- Arbitration: lowest-index eligible flux wins. At most one FIFO pop and one write per cycle. Register updates take effect on the next clk.
- IDLE:
  - Pop size; max <- W; cnt_h <- 0; cnt_v <- 0.
  - Next state is LEFT, or stays IDLE if W==0 (token consumed, no output).
- LEFT:
  - Peek the head word without popping. Write a word of pixel 0 replicated N_TAP times.
  - Next state MID.
- MID:
  - Pop and write the word unchanged; last_pel <- pixel N_TAP-1; cnt_h <- cnt_h+N_TAP.
  - If cnt_h+N_TAP == max, go to RIGHT and clear cnt_h; otherwise stay in MID.
- RIGHT:
  - Write a word of last_pel replicated (no pop); cnt_v <- cnt_v+1.
  - If cnt_v+1 == max (square block, W rows), go to IDLE; otherwise go to LEFT.
- Width rules: compares use SIZE_W+1 bits, so no wrap at W = 2^SIZE_W - N_TAP. W must be a multiple of N_TAP; a non-multiple is unsupported and unchecked.
- Per row: W/N_TAP input words produce W/N_TAP+2 output words. A block produces W*(W/N_TAP+2) output words.
- Boundaries:
  - Full output stalls only that flux; other fluxes proceed.
  - Fluxes interleave at word granularity and each resumes exactly where it stopped.
  - Reset mid-block discards partial rows; FIFO contents are untouched.

Optional Feature:
- Macro: ADD_H_ZERO_PAD_EN.
- Defined: LEFT and RIGHT words are all-zero pixels. last_pel is not implemented, and LEFT still requires in_pel not empty so that the row order is preserved.
- Undefined: edge replication as specified above.

Test Plan:
- Flux 0, W=8, row pixels 1..8, no backpressure:
  - Rows 0-6 use the same 1..8 pixels; row 7 uses 11..18.
  - Expect 24 writes tagged 0. Per row: {1×8}, {1..8}, {8×8}. Last row: {11×8}, {11..18}, {18×8}. Flux returns to IDLE.
- W=16, one row checked, pixels 0..15:
  - Expect {0×8}, {0..7}, {8..15}, {15×8}; cnt_h clears on the RIGHT entry.
- Both fluxes active (flux0 W=8, flux1 W=8), all FIFOs ready:
  - Flux0 always wins. Flux1 writes only after flux0 returns to IDLE with its size FIFO empty.
  - Tags in out_pel_din are correct throughout.
- Flux0 out_pel_full held high for 5 cycles during MID:
  - Flux1 is served during those cycles with no flux0 pops. Flux0 resumes in MID with no duplicated or dropped word.
- ext_size W=0:
  - One size pop, zero writes, state stays IDLE. A next token with W=8 is processed normally.
- rst asserted for 1 cycle mid-RIGHT:
  - Next cycle all outputs are 0 and no write occurs. A new size token restarts cleanly with a LEFT word.

Source files
------------

// File: rtl/add_h_border.sv
`default_nettype none
// ============================================================================
// Module   : add_h_border
// Purpose  : Multi-flux horizontal border inserter. Each block row is wrapped
//            with one left and one right padding word; one flux served/cycle.
//            Define ADD_H_ZERO_PAD_EN for zero padding instead of edge copy.
// Revision : 1.0
// ============================================================================
module add_h_border #(
    parameter int FLUX   = 2,
    parameter int N_TAP  = 8,
    parameter int PEL_W  = 8,
    parameter int SIZE_W = 7,
    parameter int TAG_W  = $clog2(FLUX)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TAG_W+N_TAP*PEL_W-1:0] in_pel_dout,
    input  logic [FLUX-1:0]              in_pel_empty,
    output logic [FLUX-1:0]              in_pel_read,
    input  logic [TAG_W+SIZE_W-1:0]      ext_size_dout,
    input  logic [FLUX-1:0]              ext_size_empty,
    output logic [FLUX-1:0]              ext_size_read,
    output logic [TAG_W+N_TAP*PEL_W-1:0] out_pel_din,
    input  logic [FLUX-1:0]              out_pel_full,
    output logic                         out_pel_write
);
    localparam int WORD_W = N_TAP * PEL_W;
    localparam int CNT_W  = SIZE_W + 1;
    localparam logic [CNT_W-1:0] C_STEP = CNT_W'(N_TAP);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_MID   = 2'd2,
        S_RIGHT = 2'd3
    } state_t;

    state_t            state_q [FLUX];
    state_t            state_d [FLUX];
    logic [SIZE_W-1:0] max_q   [FLUX];
    logic [SIZE_W-1:0] max_d   [FLUX];
    logic [SIZE_W-1:0] cnt_h_q [FLUX];
    logic [SIZE_W-1:0] cnt_h_d [FLUX];
    logic [SIZE_W-1:0] cnt_v_q [FLUX];
    logic [SIZE_W-1:0] cnt_v_d [FLUX];
`ifndef ADD_H_ZERO_PAD_EN
    logic [PEL_W-1:0]  last_pel_q [FLUX];
    logic [PEL_W-1:0]  last_pel_d [FLUX];
`endif

    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_pad_left;
    logic [SIZE_W-1:0] w_size;
    logic [FLUX-1:0]   w_elig;
    logic              w_found;
    logic [CNT_W-1:0]  w_h_next;
    logic [CNT_W-1:0]  w_v_next;
    logic              w_unused_tags;

    assign w_word        = in_pel_dout[WORD_W-1:0];
    assign w_size        = ext_size_dout[SIZE_W-1:0];
    assign w_unused_tags = ^{in_pel_dout[TAG_W+WORD_W-1:WORD_W],
                             ext_size_dout[TAG_W+SIZE_W-1:SIZE_W]};

`ifdef ADD_H_ZERO_PAD_EN
    assign w_pad_left = '0;
`else
    assign w_pad_left = {N_TAP{w_word[PEL_W-1:0]}};
`endif

    // LEFT still waits for pel data so a row never starts ahead of its pixels
    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            case (state_q[f])
                S_IDLE:  w_elig[f] = !ext_size_empty[f];
                S_LEFT,
                S_MID:   w_elig[f] = !in_pel_empty[f] && !out_pel_full[f];
                default: w_elig[f] = !out_pel_full[f];
            endcase
        end
    end

    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            state_d[f]    = state_q[f];
            max_d[f]      = max_q[f];
            cnt_h_d[f]    = cnt_h_q[f];
            cnt_v_d[f]    = cnt_v_q[f];
`ifndef ADD_H_ZERO_PAD_EN
            last_pel_d[f] = last_pel_q[f];
`endif
        end
        in_pel_read   = '0;
        ext_size_read = '0;
        out_pel_write = 1'b0;
        out_pel_din   = '0;
        w_found       = 1'b0;
        w_h_next      = '0;
        w_v_next      = '0;

        for (int f = 0; f < FLUX; f++) begin
            if (!w_found && w_elig[f]) begin
                w_found = 1'b1;
                case (state_q[f])
                    S_IDLE: begin
                        ext_size_read[f] = 1'b1;
                        max_d[f]         = w_size;
                        cnt_h_d[f]       = '0;
                        cnt_v_d[f]       = '0;
                        state_d[f]       = (w_size == '0) ? S_IDLE : S_LEFT;
                    end
                    S_LEFT: begin
                        out_pel_write = 1'b1;
                        out_pel_din   = {TAG_W'(f), w_pad_left};
                        state_d[f]    = S_MID;
                    end
                    S_MID: begin
                        in_pel_read[f] = 1'b1;
                        out_pel_write  = 1'b1;
                        out_pel_din    = {TAG_W'(f), w_word};
`ifndef ADD_H_ZERO_PAD_EN
                        last_pel_d[f]  = w_word[WORD_W-1 -: PEL_W];
`endif
                        // Extra bit keeps the compare exact at the largest width
                        w_h_next = {1'b0, cnt_h_q[f]} + C_STEP;
                        if (w_h_next == {1'b0, max_q[f]}) begin
                            state_d[f] = S_RIGHT;
                            cnt_h_d[f] = '0;
                        end else begin
                            cnt_h_d[f] = w_h_next[SIZE_W-1:0];
                        end
                    end
                    default: begin
                        out_pel_write = 1'b1;
`ifdef ADD_H_ZERO_PAD_EN
                        out_pel_din   = {TAG_W'(f), {WORD_W{1'b0}}};
`else
                        out_pel_din   = {TAG_W'(f), {N_TAP{last_pel_q[f]}}};
`endif
                        w_v_next   = {1'b0, cnt_v_q[f]} + C_ONE;
                        cnt_v_d[f] = w_v_next[SIZE_W-1:0];
                        state_d[f] = (w_v_next == {1'b0, max_q[f]}) ? S_IDLE : S_LEFT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < FLUX; f++) begin
            if (rst) begin
                state_q[f]    <= S_IDLE;
                max_q[f]      <= '0;
                cnt_h_q[f]    <= '0;
                cnt_v_q[f]    <= '0;
`ifndef ADD_H_ZERO_PAD_EN
                last_pel_q[f] <= '0;
`endif
            end else begin
                state_q[f]    <= state_d[f];
                max_q[f]      <= max_d[f];
                cnt_h_q[f]    <= cnt_h_d[f];
                cnt_v_q[f]    <= cnt_v_d[f];
`ifndef ADD_H_ZERO_PAD_EN
                last_pel_q[f] <= last_pel_d[f];
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_h_border.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_h_border
// Purpose  : Self-checking bench for add_h_border: scenario table, directed
//            corner sequences and random traffic against an action-list model.
// Revision : 1.0
// ============================================================================
module tb_add_h_border;
    localparam logic [1:0] K_SIZE  = 2'd0;
    localparam logic [1:0] K_LEFT  = 2'd1;
    localparam logic [1:0] K_MID   = 2'd2;
    localparam logic [1:0] K_RIGHT = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] word;
    } act_t;

    typedef struct {
        int flux;
        int w;
        int mode;
        int bp;
        int exp_writes;
    } scen_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [64:0] in_pel_dout;
    logic [1:0]  in_pel_empty;
    logic [1:0]  in_pel_read;
    logic [7:0]  ext_size_dout;
    logic [1:0]  ext_size_empty;
    logic [1:0]  ext_size_read;
    logic [64:0] out_pel_din;
    logic [1:0]  out_pel_full;
    logic        out_pel_write;

    int checks   = 0;
    int failures = 0;

    // Model state: FIFO contents and the expected action script per flux
    logic [63:0] pel_q  [2][$];
    int          size_q [2][$];
    act_t        act_q  [2][$];

    int          n_writes [2];
    int          n_size   [2];
    int          n_pop0;
    logic [63:0] wlog [$];
    logic        tlog [$];

    add_h_border dut (
        .clk            (clk),
        .rst            (rst),
        .in_pel_dout    (in_pel_dout),
        .in_pel_empty   (in_pel_empty),
        .in_pel_read    (in_pel_read),
        .ext_size_dout  (ext_size_dout),
        .ext_size_empty (ext_size_empty),
        .ext_size_read  (ext_size_read),
        .out_pel_din    (out_pel_din),
        .out_pel_full   (out_pel_full),
        .out_pel_write  (out_pel_write)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pad(input logic [7:0] p);
`ifdef ADD_H_ZERO_PAD_EN
        return 64'd0;
`else
        return {8{p}};
`endif
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // mode 0: row pixels 1..W (last row 11..), mode 1: random, mode 2: 0..W-1
    task automatic push_block(input int f, input int w, input int mode);
        act_t a;
        logic [63:0] wd;
        logic [7:0]  px;
        size_q[f].push_back(w);
        a.kind = K_SIZE; a.word = '0;
        act_q[f].push_back(a);
        for (int r = 0; r < w; r++) begin
            for (int j = 0; j < w / 8; j++) begin
                for (int i = 0; i < 8; i++) begin
                    if (mode == 0)      px = 8'(((r == w - 1) ? 11 : 1) + j * 8 + i);
                    else if (mode == 1) px = 8'($urandom);
                    else                px = 8'(j * 8 + i);
                    wd[i*8 +: 8] = px;
                end
                pel_q[f].push_back(wd);
                if (j == 0) begin
                    a.kind = K_LEFT; a.word = pad(wd[7:0]);
                    act_q[f].push_back(a);
                end
                a.kind = K_MID; a.word = wd;
                act_q[f].push_back(a);
            end
            a.kind = K_RIGHT; a.word = pad(wd[63:56]);
            act_q[f].push_back(a);
        end
    endtask

    // Called at a negedge: drive inputs, check outputs, update model, advance.
    task automatic step(input logic [1:0] full_m, input logic do_rst);
        int          sel;
        logic [1:0]  k;
        logic [1:0]  e_pr, e_sr;
        logic        e_w;
        logic [64:0] e_din;
        sel = -1;
        for (int f = 0; f < 2; f++) begin
            if (sel < 0 && act_q[f].size() > 0) begin
                k = act_q[f][0].kind;
                if ((k == K_SIZE && size_q[f].size() > 0) ||
                    (k == K_RIGHT && !full_m[f]) ||
                    ((k == K_LEFT || k == K_MID) && pel_q[f].size() > 0 && !full_m[f]))
                    sel = f;
            end
        end
        rst = do_rst;
        for (int f = 0; f < 2; f++) begin
            in_pel_empty[f]   = (pel_q[f].size() == 0);
            ext_size_empty[f] = (size_q[f].size() == 0);
        end
        out_pel_full  = full_m;
        in_pel_dout   = {1'($urandom), 32'($urandom), 32'($urandom)};
        ext_size_dout = 8'($urandom);
        e_pr = '0; e_sr = '0; e_w = 1'b0; e_din = '0;
        if (sel >= 0) begin
            if (pel_q[sel].size() > 0)  in_pel_dout   = {1'($urandom), pel_q[sel][0]};
            if (size_q[sel].size() > 0) ext_size_dout = {1'($urandom), 7'(size_q[sel][0])};
            k = act_q[sel][0].kind;
            if (k == K_SIZE) e_sr[sel] = 1'b1;
            else begin
                e_w   = 1'b1;
                e_din = {1'(sel), act_q[sel][0].word};
                if (k == K_MID) e_pr[sel] = 1'b1;
            end
        end
        #1;
        chk("in_pel_read", 65'(in_pel_read), 65'(e_pr));
        chk("ext_size_read", 65'(ext_size_read), 65'(e_sr));
        chk("out_pel_write", 65'(out_pel_write), 65'(e_w));
        if (e_w) chk("out_pel_din", out_pel_din, e_din);
        if (out_pel_write === 1'b1) begin
            n_writes[out_pel_din[64]]++;
            tlog.push_back(out_pel_din[64]);
            if (out_pel_din[64] == 1'b0) wlog.push_back(out_pel_din[63:0]);
        end
        if (in_pel_read[0] === 1'b1) n_pop0++;
        for (int f = 0; f < 2; f++) if (ext_size_read[f] === 1'b1) n_size[f]++;
        if (do_rst) begin
            act_q[0].delete();
            act_q[1].delete();
        end else if (sel >= 0) begin
            k = act_q[sel][0].kind;
            void'(act_q[sel].pop_front());
            if (k == K_SIZE) void'(size_q[sel].pop_front());
            if (k == K_MID)  void'(pel_q[sel].pop_front());
        end
        @(negedge clk);
    endtask

    task automatic clear_stats();
        n_writes[0] = 0; n_writes[1] = 0;
        n_size[0]   = 0; n_size[1]   = 0;
        n_pop0 = 0;
        wlog.delete();
        tlog.delete();
    endtask

    task automatic run(input int bp);
        int n;
        logic [1:0] fm;
        n = 0;
        while ((act_q[0].size() > 0 || act_q[1].size() > 0) && n < 3000) begin
            fm[0] = ($urandom_range(99) < bp);
            fm[1] = ($urandom_range(99) < bp);
            step(fm, 1'b0);
            n++;
        end
        chk("run_timeout", 65'(n >= 3000), 65'(0));
    endtask

    scen_t tbl[5];

    initial begin
        int c0, pops_before, w1_before, w0, w1;
        rst = 1'b1;
        in_pel_empty = '1; ext_size_empty = '1; out_pel_full = '0;
        in_pel_dout = '0; ext_size_dout = '0;
        repeat (2) @(negedge clk);
        clear_stats();
        step(2'b00, 1'b1);
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);

        tbl[0] = '{0, 8,  0, 0,  24};
        tbl[1] = '{0, 16, 2, 0,  64};
        tbl[2] = '{1, 0,  0, 0,  0};
        tbl[3] = '{1, 8,  1, 30, 24};
        tbl[4] = '{0, 24, 1, 40, 120};
        for (int i = 0; i < 5; i++) begin
            clear_stats();
            push_block(tbl[i].flux, tbl[i].w, tbl[i].mode);
            run(tbl[i].bp);
            chk("scen_writes", 65'(n_writes[tbl[i].flux]), 65'(tbl[i].exp_writes));
            chk("scen_size_pops", 65'(n_size[tbl[i].flux]), 65'(1));
            if (i == 0 && wlog.size() == 24) begin
                chk("w8_row0_left", 65'(wlog[0]), 65'(pad(8'd1)));
                chk("w8_row0_mid", 65'(wlog[1]), 65'(64'h0807060504030201));
                chk("w8_row7_left", 65'(wlog[21]), 65'(pad(8'd11)));
                chk("w8_row7_mid", 65'(wlog[22]), 65'(64'h1211100F0E0D0C0B));
                chk("w8_row7_right", 65'(wlog[23]), 65'(pad(8'd18)));
            end
            if (i == 1 && wlog.size() >= 4) begin
                chk("w16_left", 65'(wlog[0]), 65'(pad(8'd0)));
                chk("w16_mid0", 65'(wlog[1]), 65'(64'h0706050403020100));
                chk("w16_mid1", 65'(wlog[2]), 65'(64'h0F0E0D0C0B0A0908));
                chk("w16_right", 65'(wlog[3]), 65'(pad(8'd15)));
            end
        end

        // Both fluxes loaded: flux0 must finish before flux1 writes anything
        clear_stats();
        push_block(0, 8, 1);
        push_block(1, 8, 1);
        run(0);
        c0 = 0;
        for (int i = 0; i < 24 && i < tlog.size(); i++) if (tlog[i] == 1'b0) c0++;
        chk("arb_flux0_first", 65'(c0), 65'(24));
        chk("arb_total", 65'(tlog.size()), 65'(48));

        // Flux0 stalled mid-row: flux1 proceeds, flux0 resumes intact
        clear_stats();
        push_block(0, 16, 1);
        push_block(1, 8, 1);
        repeat (3) step(2'b00, 1'b0);
        chk("stall_in_mid", 65'(act_q[0][0].kind), 65'(K_MID));
        pops_before = n_pop0;
        w1_before   = n_writes[1];
        repeat (5) step(2'b01, 1'b0);
        chk("stall_no_f0_pop", 65'(n_pop0 - pops_before), 65'(0));
        chk("stall_f1_writes", 65'(n_writes[1] - w1_before), 65'(4));
        run(0);
        chk("stall_f0_total", 65'(n_writes[0]), 65'(64));
        chk("stall_f1_total", 65'(n_writes[1]), 65'(24));

        // Reset while flux0 sits in a mid-block RIGHT
        clear_stats();
        push_block(0, 8, 1);
        for (int n = 0; n < 20 && act_q[0].size() > 0 && act_q[0][0].kind != K_RIGHT; n++)
            step(2'b00, 1'b0);
        chk("rst_reached_right", 65'(act_q[0][0].kind), 65'(K_RIGHT));
        step(2'b00, 1'b1);
        w0 = n_writes[0];
        step(2'b00, 1'b0);
        chk("rst_no_write", 65'(n_writes[0] - w0), 65'(0));
        pel_q[0].delete();
        clear_stats();
        push_block(0, 8, 0);
        run(0);
        chk("rst_restart_writes", 65'(n_writes[0]), 65'(24));
        if (wlog.size() > 0) chk("rst_restart_left", 65'(wlog[0]), 65'(pad(8'd1)));

        // Random traffic on both fluxes with random backpressure
        for (int r = 0; r < 6; r++) begin
            clear_stats();
            w0 = 8 * $urandom_range(0, 2);
            w1 = 8 * $urandom_range(0, 2);
            push_block(0, w0, 1);
            push_block(1, w1, 1);
            run($urandom_range(0, 50));
            chk("rand_f0_writes", 65'(n_writes[0]), 65'(w0 * (w0 / 8 + 2)));
            chk("rand_f1_writes", 65'(n_writes[1]), 65'(w1 * (w1 / 8 + 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
